// File: rtl/inst_pkg.sv
// inst_pkg: definitions shared by the fetch stage, inst_queue and decode.
//   OP_IADD, OP_LDM, OP_LDD, OP_STD : 5-bit opcodes (word[15:11]) that are
//                                     followed by a 16-bit immediate word
//   qstate_e                        : pairing FSM states
//   isImmOpcode()                   : opcode -> needs an immediate
package inst_pkg;

  localparam logic [4:0] OP_IADD = 5'h08;
  localparam logic [4:0] OP_LDM  = 5'h10;
  localparam logic [4:0] OP_LDD  = 5'h11;
  localparam logic [4:0] OP_STD  = 5'h12;

  typedef enum logic {
    S_OP  = 1'b0,
    S_IMM = 1'b1
  } qstate_e;

  function automatic logic isImmOpcode(input logic [4:0] op);
    return (op == OP_IADD) || (op == OP_LDM) || (op == OP_LDD) || (op == OP_STD);
  endfunction

endpackage

// File: rtl/inst_queue_imm_classifier.sv
// imm_classifier: combinational immediate detector, shared with decode.
//   opcode   in  5  word[15:11] of an instruction-memory word
//   needsImm out 1  the opcode is followed by an immediate word
module imm_classifier
  import inst_pkg::*;
(
  input  logic [4:0] opcode,
  output logic       needsImm
);

  always_comb begin
    needsImm = isImmOpcode(opcode);
  end

endmodule

// File: rtl/inst_queue.sv
// inst_queue: decode-side receiver for the 16-bit fetch word stream. Pairs
// immediate-bearing opcodes with their following word and buffers complete
// {instruction, immediate, pc} entries in a DEPTH-entry FIFO.
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   flush        in   redirect; empties queue, discards any accept this cycle
//   word_valid   in   fetch word present
//   word         in   16-bit fetched word
//   word_pc      in   address of word
//   word_ready   out  queue can accept a word (count != DEPTH)
//   inst_valid   out  head entry valid (count != 0)
//   inst_ready   in   decode consumes head
//   instruction  out  head opcode word
//   immediate    out  head immediate word (0 if none)
//   inst_pc      out  pc of head opcode word
//   has_imm      out  head carried an immediate
//   stat_drop    out  saturating count of flushes that discarded work
//                     (port exists only when INSTQ_STATS_EN is defined)
module inst_queue
  import inst_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            word_valid,
  input  logic [15:0]     word,
  input  logic [PC_W-1:0] word_pc,
  output logic            word_ready,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [15:0]     instruction,
  output logic [15:0]     immediate,
  output logic [PC_W-1:0] inst_pc,
  output logic            has_imm
`ifdef INSTQ_STATS_EN
  ,output logic [15:0]    stat_drop
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [15:0]     memInst [DEPTH];
  logic [15:0]     memImm  [DEPTH];
  logic [PC_W-1:0] memPc   [DEPTH];
  logic            memHas  [DEPTH];

  logic [PTR_W-1:0] rdPtr, wrPtr;
  logic [PTR_W:0]   count;

  qstate_e         state, nextState;
  logic [15:0]     holdInst;
  logic [PC_W-1:0] holdPc;

  logic            needsImm;
  logic            accept, pop, push, latchHold;
  logic [15:0]     pushInst, pushImm;
  logic [PC_W-1:0] pushPc;
  logic            pushHas;

  imm_classifier uClassifier (
    .opcode   (word[15:11]),
    .needsImm (needsImm)
  );

  assign word_ready  = (count != FULL_COUNT);
  assign inst_valid  = (count != '0);
  assign accept      = word_valid & word_ready;
  assign pop         = inst_valid & inst_ready;

  assign instruction = memInst[rdPtr];
  assign immediate   = memImm[rdPtr];
  assign inst_pc     = memPc[rdPtr];
  assign has_imm     = memHas[rdPtr];

  // Pairing FSM: the word after an immediate-bearing opcode is taken as
  // data, never classified.
  always_comb begin
    nextState = state;
    push      = 1'b0;
    latchHold = 1'b0;
    pushInst  = word;
    pushImm   = '0;
    pushPc    = word_pc;
    pushHas   = 1'b0;
    if (accept) begin
      unique case (state)
        S_OP: begin
          if (needsImm) begin
            latchHold = 1'b1;
            nextState = S_IMM;
          end else begin
            push = 1'b1;
          end
        end
        S_IMM: begin
          push      = 1'b1;
          pushInst  = holdInst;
          pushImm   = word;
          pushPc    = holdPc;
          pushHas   = 1'b1;
          nextState = S_OP;
        end
        default: nextState = S_OP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_OP;
      holdInst <= '0;
      holdPc   <= '0;
    end else if (flush) begin
      state    <= S_OP;
      holdInst <= '0;
      holdPc   <= '0;
    end else begin
      state <= nextState;
      if (latchHold) begin
        holdInst <= word;
        holdPc   <= word_pc;
      end
    end
  end

  // Storage is reset so the head outputs read zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        memInst[i] <= '0;
        memImm[i]  <= '0;
        memPc[i]   <= '0;
        memHas[i]  <= 1'b0;
      end
    end else if (push && !flush) begin
      memInst[wrPtr] <= pushInst;
      memImm[wrPtr]  <= pushImm;
      memPc[wrPtr]   <= pushPc;
      memHas[wrPtr]  <= pushHas;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef INSTQ_STATS_EN
  logic discard;
  assign discard = (count != '0) || (state == S_IMM) || accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_drop <= '0;
    end else if (flush && discard && (stat_drop != '1)) begin
      stat_drop <= stat_drop + 1'b1;
    end
  end
`endif

endmodule

// File: doc/inst_queue.md
# inst_queue

Decode-side receiver for the 16-bit fetch word stream. It consumes one word per handshake, pairs each immediate-bearing opcode with the word that follows it, and buffers complete {instruction, immediate, pc} entries in a small FIFO for the decode stage. Jump and interrupt redirects flush it. It sits between the fetch stage output and the decode stage input, replacing fetch-side immediate detection.

## Interface
- DEPTH, 4: FIFO entries, power of two, ≥2
- PC_W, 32: pc width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- flush  in  1  redirect (jump/interrupt); synchronous, highest priority
- word_valid  in  1  fetch word present
- word  in  16  fetched instruction-memory word
- word_pc  in  PC_W  address of `word`
- word_ready  out  1  word accepted this cycle when word_valid & word_ready
- inst_valid  out  1  FIFO head holds a complete instruction
- inst_ready  in  1  decode consumes head (low = decode stall)
- instruction  out  16  head opcode word
- immediate  out  16  head immediate word; 16'h0000 if none
- inst_pc  out  PC_W  pc of head opcode word
- has_imm  out  1  head carried an immediate
- stat_drop  out  16  present only with INSTQ_STATS_EN

## Operation
- Classification: the word takes an immediate iff word[15:11] ∈ {IADD, LDM, LDD, STD}. The opcode values are package constants.
- FSM state S_OP: an accepted word with no immediate is pushed as {word, 16'h0, word_pc, 0}.
- FSM state S_OP: an accepted immediate-bearing word is latched into hold_inst/hold_pc, then the FSM moves to S_IMM.
- FSM state S_IMM: the next accepted word is pushed as {hold_inst, word, hold_pc, 1}, then the FSM returns to S_OP. The immediate word is never classified.
- word_ready = (count != DEPTH). It is registered-state only and has no combinational path from inst_ready.
- inst_valid = (count != 0). The head outputs come straight from the FIFO read slot.
- Pop occurs when inst_valid & inst_ready.
- Push and pop in the same cycle leave count unchanged.
- flush=1: count←0, rd/wr pointers←0, FSM←S_OP, hold registers←0.
- flush=1: any word accepted in the same cycle is discarded.
- flush=1: any pop in the same cycle is ignored.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Reset (rst=0, async): state and values as for flush. Outputs at reset: word_ready=1, inst_valid=0, instruction=0, immediate=0, inst_pc=0, has_imm=0, stat_drop=0.

## Timing
- Latency: a completing word accepted at edge N gives inst_valid=1 after edge N; decode can pop in the following cycle.
- Throughput: one word per cycle. A two-word instruction takes two accepts.
- Full FIFO: word_ready=0. A pop in that cycle re-asserts word_ready one cycle later, not the same cycle.
- Full FIFO while in S_IMM: the immediate is held off by word_ready=0. hold_* are retained indefinitely.
- flush overrides everything. After flush at edge N: inst_valid=0 and word_ready=1 following edge N. A word presented in cycle N+1 is treated as an opcode.
- rst deasserted mid-stream: the first accepted word is an opcode.

## Configuration
- INSTQ_STATS_EN defined: adds the stat_drop port, a 16-bit saturating counter (stops at 16'hFFFF). It increments by one per flush that discards work, meaning count≠0 or FSM=S_IMM or a word was accepted that cycle. It is cleared only by rst.
- INSTQ_STATS_EN undefined: no port, no counter logic; behaviour is otherwise identical.

## Structure
- Shared package inst_pkg holds the opcode constants OP_IADD, OP_LDM, OP_LDD, OP_STD (5-bit) and the state enum {S_OP, S_IMM}. The fetch side uses the same package.
- One sub-module, imm_classifier: combinational, word[15:11] → needs_imm. The decode stage reuses it.
- The FIFO storage is inline. It has no separate module.

## Test plan
- Single-word instructions: three no-immediate words 16'h0800, 16'h1000, 16'h1800 at pc 0, 1, 2 with inst_ready=1 → three entries with immediate=0 and has_imm=0, each inst_valid one cycle after its accept.
- Immediate pair: LDM opcode word at pc 0x20, then 16'hBEEF at pc 0x21 → one entry {LDM word, 16'hBEEF, pc 0x20, has_imm=1}. The immediate word is not decoded as an opcode, even when its bits [15:11] match LDM.
- Full/backpressure: inst_ready=0 with DEPTH=4 single-word instructions → word_ready=0 after the 4th push. Raise inst_ready for one cycle → one pop, then word_ready=1 the next cycle. FIFO order is preserved across pointer wrap over 10 instructions.
- Flush mid-pair: an IADD opcode is accepted, then flush is asserted together with a valid word → FIFO empty, FSM back to S_OP. The next word is treated as an opcode. With INSTQ_STATS_EN, stat_drop=1.
- Reset mid-operation: assert rst=0 asynchronously with 3 entries queued → all outputs return to their reset values before the next clk edge.
- Simultaneous push and pop at count=DEPTH-1 → count stays DEPTH-1, and the head advances correctly.
